pb_entry_unit: RTL and testbench
================================

PB_ENTRY_UNIT -- requirements
Module: pb_entry_unit

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable clk cycles a synchronized button level must hold before it is accepted (range 1..255).
REQ-002 Port clk, input, 1 bit: the single clock; the 100 Hz board clock in the FPGA build.
REQ-003 Port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port pb, input, 21 bits: raw pushbuttons with this mapping:
- pb[15:0]: hex digits 0..F.
- pb[16]: backspace.
- pb[17]: clear.
- pb[18]: add.
- pb[19]: subtract.
- pb[20]: enter.
REQ-005 Port entry_value, output, 32 bits: operand currently being typed, for the 7-segment display.
REQ-006 Port digit_count, output, 4 bits: number of digits in entry_value, 0..8.
REQ-007 Port key_strobe, output, 1 bit: one-cycle pulse for each accepted key press.
REQ-008 Port op_valid, output, 1 bit: an operand/operator pair is offered downstream.
REQ-009 Port op_ready, input, 1 bit: the downstream calculator accepts the offered pair.
REQ-010 Port op_value, output, 32 bits: the offered operand.
REQ-011 Port op_code, output, 2 bits: offered operator; 01 add, 10 subtract, 11 enter; 00 is never offered.

Function
REQ-012 Each pb bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 A press SHALL be a 0->1 transition of the accepted (debounced) level of a button; releases SHALL produce no action.
REQ-014 key_strobe and the resulting state or register update SHALL occur on the same clk edge, exactly one cycle wide.
REQ-015 When several buttons are pressed in the same cycle, only the highest-numbered one SHALL be processed; the others are discarded, not queued.
REQ-016 The FSM SHALL have three states:
- IDLE: digit_count 0.
- ENTRY: digit_count >= 1.
- SEND: op_valid high.
REQ-017 Digit press in IDLE or ENTRY with digit_count < 8: entry_value <= {entry_value[27:0], d}, digit_count +1, next state ENTRY.
REQ-018 Digit press with digit_count == 8 SHALL be ignored, with no strobe side effects beyond key_strobe.
REQ-019 Backspace: entry_value <= entry_value >> 4, digit_count -1; the state becomes IDLE when the count reaches 0; backspace at count 0 has no effect.
REQ-020 Clear in IDLE or ENTRY: entry_value 0, digit_count 0, state IDLE.
REQ-021 Add, subtract or enter in IDLE or ENTRY:
- op_value <= entry_value; op_code <= mapping.
- op_valid <= 1; state SEND.
- An empty entry is allowed and sends 0.
REQ-022 In SEND, op_value and op_code SHALL be held stable while op_valid=1 and op_ready=0.
REQ-023 A transfer SHALL occur on an edge with op_valid=1 and op_ready=1; on that edge op_valid <= 0, entry_value <= 0, digit_count <= 0, state IDLE.
REQ-024 All presses in SEND, including clear, SHALL be ignored except for key_strobe.
REQ-025 op_ready while op_valid=0 SHALL have no effect.
REQ-026 A press and a transfer on the same edge: the transfer completes and the press is dropped.

Reset
REQ-027 nrst low SHALL immediately set all outputs, registers and synchronizers to 0 and the state to IDLE, including mid-SEND, where the pending operand is lost.
REQ-028 After nrst rises, a button held through reset SHALL NOT produce a press until it is released and pressed again.

Configuration
REQ-029 With PB_DEBOUNCE_EN defined:
- Per-button 8-bit counters implement DEBOUNCE_CYCLES.
- Latency from pb rising to key_strobe SHALL be 3 + DEBOUNCE_CYCLES clk edges.
- Glitches shorter than DEBOUNCE_CYCLES cycles are rejected.
REQ-030 With PB_DEBOUNCE_EN undefined:
- The synchronizer output is the accepted level.
- Latency SHALL be 3 clk edges.
- DEBOUNCE_CYCLES is unused.

Verification
REQ-031 No debounce: press pb[1], pb[2], pb[10] one at a time -> three key_strobes, each 3 edges after its press; entry_value 0x0000012A, digit_count 3.
REQ-032 Press nine digits 1..9 -> entry_value 0x12345678, digit_count 8; pb[16] twice -> 0x00123456, count 6.
REQ-033 Entry 0x5, press pb[18] with op_ready=0 for 5 cycles, then op_ready=1 -> op_value 0x5, op_code 01 held 5 cycles; one transfer, then op_valid 0, entry_value 0; a digit pressed during SEND is ignored.
REQ-034 pb[3] and pb[20] pressed simultaneously with entry 0x7 -> only enter processed: op_value 0x7, op_code 11.
REQ-035 PB_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: pb[4] high for 3 cycles -> no strobe; high for 10 cycles -> one strobe at edge 7.
REQ-036 nrst pulsed low while op_valid=1 -> op_valid, entry_value, digit_count 0 asynchronously; pb held through reset gives no strobe until re-pressed.

Source files
------------

// File: rtl/pb_entry_unit.sv
// pb_entry_unit: pushbutton hex-operand entry front end for a calculator.
// Raw buttons are synchronized (and optionally debounced when PB_DEBOUNCE_EN
// is defined), rising edges become key presses, and a small FSM builds a
// 32-bit hex operand and offers operand/operator pairs over valid/ready.
module pb_entry_unit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [20:0] pb,
  output logic [31:0] entry_value,
  output logic [3:0]  digit_count,
  output logic        key_strobe,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_value,
  output logic [1:0]  op_code
);
  localparam int NB = 21;

  typedef enum logic [1:0] {IDLE = 2'd0, ENTRY = 2'd1, SEND = 2'd2} state_t;

  logic [NB-1:0] sync1_q, sync2_q;
  logic [NB-1:0] lvl, prev_q, prev_d, arm_q, arm_d, press;
  logic [1:0]    rdy_q;

  // Two-flop synchronizer plus a reset-settle marker that goes high once the
  // synchronizer holds real samples.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      rdy_q   <= '0;
    end else begin
      sync1_q <= pb;
      sync2_q <= sync1_q;
      rdy_q   <= {rdy_q[0], 1'b1};
    end
  end

`ifdef PB_DEBOUNCE_EN
  localparam logic [7:0] DB8 = 8'(DEBOUNCE_CYCLES);
  logic [NB-1:0][7:0] cnt_q, cnt_d;
  logic [NB-1:0]      lvl_q, lvl_d;

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    for (int i = 0; i < NB; i++) begin
      if (sync2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] + 8'd1 == DB8) begin
        lvl_d[i] = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
      lvl_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign lvl = lvl_q;
`else
  assign lvl = sync2_q;
`endif

  // A button is armed only after it has been seen released following reset,
  // so a button held through reset cannot fake a press when reset lifts.
  always_comb begin
    arm_d  = arm_q | ({NB{rdy_q[1]}} & ~sync2_q & ~lvl);
    prev_d = lvl;
  end

  assign press = lvl & ~prev_q & arm_q;

  // Edge-detect history and arming flags.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      prev_q <= '0;
      arm_q  <= '0;
    end else begin
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  // Highest-numbered simultaneous press wins; the rest are dropped.
  logic       key_vld;
  logic [4:0] key_idx;
  always_comb begin
    key_vld = 1'b0;
    key_idx = '0;
    for (int i = 0; i < NB; i++) begin
      if (press[i]) begin
        key_vld = 1'b1;
        key_idx = 5'(i);
      end
    end
  end

  state_t      state_q, state_d;
  logic [31:0] entry_q, entry_d, opv_q, opv_d;
  logic [3:0]  count_q, count_d;
  logic [1:0]  opc_q, opc_d;
  logic        valid_q, valid_d, strobe_q, strobe_d;

  // Entry FSM next-state: digit shift-in, backspace, clear, operator offer,
  // and handshake completion while in SEND (presses there only strobe).
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    count_d  = count_q;
    opv_d    = opv_q;
    opc_d    = opc_q;
    valid_d  = valid_q;
    strobe_d = key_vld;
    case (state_q)
      SEND: begin
        if (op_ready) begin
          valid_d = 1'b0;
          entry_d = '0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        if (key_vld) begin
          if (key_idx < 5'd16) begin
            if (count_q < 4'd8) begin
              entry_d = {entry_q[27:0], key_idx[3:0]};
              count_d = count_q + 4'd1;
              state_d = ENTRY;
            end
          end else begin
            case (key_idx)
              5'd16: begin
                if (count_q != 4'd0) begin
                  entry_d = entry_q >> 4;
                  count_d = count_q - 4'd1;
                  state_d = (count_q == 4'd1) ? IDLE : ENTRY;
                end
              end
              5'd17: begin
                entry_d = '0;
                count_d = '0;
                state_d = IDLE;
              end
              default: begin
                opv_d   = entry_q;
                opc_d   = (key_idx == 5'd18) ? 2'b01 :
                          (key_idx == 5'd19) ? 2'b10 : 2'b11;
                valid_d = 1'b1;
                state_d = SEND;
              end
            endcase
          end
        end
      end
    endcase
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      count_q  <= '0;
      opv_q    <= '0;
      opc_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      opv_q    <= opv_d;
      opc_q    <= opc_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign entry_value = entry_q;
  assign digit_count = count_q;
  assign key_strobe  = strobe_q;
  assign op_valid    = valid_q;
  assign op_value    = opv_q;
  assign op_code     = opc_q;
endmodule

// File: tb/tb_pb_entry_unit.sv
// Bench for pb_entry_unit: table of key presses, hand sequences for the
// handshake / reset / debounce corners, and a randomized run against a
// key-level model of the entry rules.
module tb_pb_entry_unit;
  localparam int DB = 4;
`ifdef PB_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [20:0] pb;
  logic        op_ready;
  logic [31:0] entry_value, op_value;
  logic [3:0]  digit_count;
  logic        key_strobe, op_valid;
  logic [1:0]  op_code;

  int nvec = 0;
  int nerr = 0;

  pb_entry_unit #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .nrst(nrst), .pb(pb),
    .entry_value(entry_value), .digit_count(digit_count),
    .key_strobe(key_strobe), .op_valid(op_valid), .op_ready(op_ready),
    .op_value(op_value), .op_code(op_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] pb;
    logic [31:0] ev;
    logic [3:0]  dc;
    logic        ov;
    logic [31:0] opv;
    logic [1:0]  opc;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [20:0] b(input int i);
    logic [20:0] one;
    one = 21'd1;
    return one << i;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm, input logic [31:0] ev, input logic [3:0] dc, input logic ov);
    chk({nm, "_entry"}, entry_value, ev);
    chk({nm, "_count"}, 32'(digit_count), 32'(dc));
    chk({nm, "_valid"}, 32'(op_valid), 32'(ov));
  endtask

  // Hold a pattern long enough to be accepted, checking the strobe lands
  // exactly LAT edges after the press and nowhere else, then release.
  task automatic press(input logic [20:0] m);
    @(negedge clk) pb = m;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk); #1;
      chk("strobe_press", 32'(key_strobe), 32'(e == LAT));
    end
    @(negedge clk) pb = '0;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(posedge clk); #1;
      chk("strobe_release", 32'(key_strobe), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    #1;
    @(negedge clk) nrst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Key-level reference model.
  logic [31:0] m_ev, m_opv;
  logic [3:0]  m_dc;
  logic        m_ov, m_st;
  logic [1:0]  m_opc;

  task automatic model_step(input logic [20:0] p, input logic rdy);
    int k;
    k = -1;
    for (int i = 20; i >= 0; i--) if (p[i] && k < 0) k = i;
    m_st = (p != '0);
    if (m_ov) begin
      if (rdy) begin
        m_ov = 1'b0; m_ev = '0; m_dc = '0;
      end
    end else if (k >= 0) begin
      if (k < 16) begin
        if (m_dc < 8) begin
          m_ev = m_ev * 16 + 32'(k);
          m_dc = m_dc + 1;
        end
      end else if (k == 16) begin
        if (m_dc > 0) begin
          m_ev = m_ev / 16;
          m_dc = m_dc - 1;
        end
      end else if (k == 17) begin
        m_ev = '0; m_dc = '0;
      end else begin
        m_opv = m_ev;
        m_opc = 2'(k - 17);
        m_ov  = 1'b1;
      end
    end
  endtask

  initial begin
    nrst = 1'b0;
    pb = '0;
    op_ready = 1'b0;

    // Reset state.
    #12;
    chk_state("reset", 32'd0, 4'd0, 1'b0);
    chk("reset_strobe", 32'(key_strobe), 32'd0);
    chk("reset_opv", op_value, 32'd0);
    chk("reset_opc", 32'(op_code), 32'd0);
    @(negedge clk) nrst = 1'b1;
    repeat (3) @(posedge clk);

    // Key sequence table.
    tbl.push_back('{b(1),  32'h0000_0001, 4'd1, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(2),  32'h0000_0012, 4'd2, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(10), 32'h0000_012A, 4'd3, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(17), 32'h0,         4'd0, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(16), 32'h0,         4'd0, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(1),  32'h0000_0001, 4'd1, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(2),  32'h0000_0012, 4'd2, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(3),  32'h0000_0123, 4'd3, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(4),  32'h0000_1234, 4'd4, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(5),  32'h0001_2345, 4'd5, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(6),  32'h0012_3456, 4'd6, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(7),  32'h0123_4567, 4'd7, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(8),  32'h1234_5678, 4'd8, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(9),  32'h1234_5678, 4'd8, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(16), 32'h0123_4567, 4'd7, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(16), 32'h0012_3456, 4'd6, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(17), 32'h0,         4'd0, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(7),  32'h0000_0007, 4'd1, 1'b0, 32'h0, 2'd0});
    tbl.push_back('{b(3) | b(20), 32'h0000_0007, 4'd1, 1'b1, 32'h7, 2'd3});
    for (int i = 0; i < tbl.size(); i++) begin
      press(tbl[i].pb);
      chk_state("tbl", tbl[i].ev, tbl[i].dc, tbl[i].ov);
      if (tbl[i].ov) begin
        chk("tbl_opv", op_value, tbl[i].opv);
        chk("tbl_opc", 32'(op_code), 32'(tbl[i].opc));
      end
    end

    // Transfer the pending enter.
    @(negedge clk) op_ready = 1'b1;
    @(posedge clk); #1;
    chk_state("xfer_enter", 32'd0, 4'd0, 1'b0);
    @(negedge clk) op_ready = 1'b0;

    // Backpressured add with a digit pressed while waiting.
    press(b(5));
    press(b(18));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(op_valid), 32'd1);
      chk("hold_opv", op_value, 32'h5);
      chk("hold_opc", 32'(op_code), 32'd1);
    end
    press(b(9));
    chk_state("send_ignore", 32'h5, 4'd1, 1'b1);
    press(b(17));
    chk_state("send_clear_ignore", 32'h5, 4'd1, 1'b1);
    chk("send_opv", op_value, 32'h5);
    @(negedge clk) op_ready = 1'b1;
    @(posedge clk); #1;
    chk_state("xfer_add", 32'd0, 4'd0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("ready_idle", 32'(op_valid), 32'd0);
    end
    @(negedge clk) op_ready = 1'b0;

    // Empty entry sends zero with subtract.
    press(b(19));
    chk_state("empty_sub", 32'd0, 4'd0, 1'b1);
    chk("empty_opv", op_value, 32'd0);
    chk("empty_opc", 32'(op_code), 32'd2);
    @(negedge clk) op_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk) op_ready = 1'b0;
    chk("empty_xfer", 32'(op_valid), 32'd0);

    // Asynchronous reset mid-SEND with a button held through it.
    press(b(3));
    press(b(20));
    chk("pre_rst_valid", 32'(op_valid), 32'd1);
    @(negedge clk) pb = b(5);
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk_state("async_rst", 32'd0, 4'd0, 1'b0);
    chk("async_rst_strobe", 32'(key_strobe), 32'd0);
    @(negedge clk) nrst = 1'b1;
    for (int c = 0; c < LAT + 8; c++) begin
      @(posedge clk); #1;
      chk("held_no_strobe", 32'(key_strobe), 32'd0);
    end
    chk_state("held_no_entry", 32'd0, 4'd0, 1'b0);
    @(negedge clk) pb = '0;
    repeat (LAT + 2) @(posedge clk);
    press(b(5));
    chk_state("repress", 32'h5, 4'd1, 1'b0);

`ifdef PB_DEBOUNCE_EN
    // Short glitch rejected, long press strobes once at edge 3 + DB.
    press(b(17));
    @(negedge clk) pb = b(4);
    repeat (3) @(posedge clk);
    @(negedge clk) pb = '0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      chk("glitch_no_strobe", 32'(key_strobe), 32'd0);
    end
    @(negedge clk) pb = b(4);
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      chk("db_strobe", 32'(key_strobe), 32'(e == 3 + DB));
      if (e == 10) begin
        @(negedge clk) pb = '0;
      end
    end
    chk_state("db_entry", 32'h4, 4'd1, 1'b0);
`else
    // Randomized run against the key-level model. A key level is seen
    // by the unit 3 edges after it is driven, so the press acted upon at
    // edge n is the rising edge between samples n-3 and n-2.
    begin
      logic [20:0] hist[$];
      logic [20:0] p;
      do_reset();
      m_ev = '0; m_dc = '0; m_ov = 1'b0; m_opv = '0; m_opc = '0; m_st = 1'b0;
      pb = '0;
      op_ready = 1'b0;
      do_reset();
      hist.push_back('0);
      for (int n = 1; n <= 1500; n++) begin
        @(negedge clk);
        if (n > 4 && $urandom_range(3) == 0) begin
          if ($urandom_range(1) == 0) pb = '0;
          else pb = b(int'($urandom_range(20))) |
                    (($urandom_range(3) == 0) ? b(int'($urandom_range(20))) : 21'd0);
        end
        op_ready = ($urandom_range(2) == 0);
        @(posedge clk);
        hist.push_back(pb);
        p = (n >= 3) ? (hist[n-2] & ~hist[n-3]) : 21'd0;
        model_step(p, op_ready);
        #1;
        chk("rnd_entry", entry_value, m_ev);
        chk("rnd_count", 32'(digit_count), 32'(m_dc));
        chk("rnd_strobe", 32'(key_strobe), 32'(m_st));
        chk("rnd_valid", 32'(op_valid), 32'(m_ov));
        if (m_ov) begin
          chk("rnd_opv", op_value, m_opv);
          chk("rnd_opc", 32'(op_code), 32'(m_opc));
        end
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
